// File: rtl/cam_init_sequencer.sv
// Table-driven camera bring-up: replays a sensor register table over I2C, honours delay
// entries, then waits for pixel PLL lock before releasing the MIPI bridge from reset.
module cam_init_sequencer #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DELAY_UNIT   = 1000,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [31:0]       rom_data_i,
    output logic              i2c_req_o,
    output logic [15:0]       i2c_addr_o,
    output logic [7:0]        i2c_data_o,
    input  logic              i2c_ready_i,
    input  logic              i2c_done_i,
    input  logic              i2c_nack_i,
    input  logic              pll_lock_i,
    output logic              mipi_reset_n_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [1:0]        err_code_o
);

    typedef enum logic [3:0] {
        StIdle, StFetch, StDecode, StI2cReq, StI2cWait, StDelay, StLockWait, StDone, StError
    } state_e;

    localparam logic [ADDR_W-1:0] LastIdx   = '1;
    localparam logic [31:0]       LockLimit = 32'(LOCK_TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [15:0]       addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic [31:0]       retry_q, retry_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [1:0]        code_q, code_d;
    logic              advance;
    logic [31:0]       delay_cycles;

    assign delay_cycles = 32'(rom_data_i[23:8]) * DELAY_UNIT;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            retry_q <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            retry_q <= retry_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // cnt_q is shared: down-counter in StDelay, up-counting lock timer in StLockWait.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        retry_d = retry_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        advance = 1'b0;
        unique case (state_q)
            StIdle, StDone, StError: begin
                if (start_i) begin
                    state_d = StFetch;
                    idx_d   = '0;
                    code_d  = 2'd0;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                unique case (rom_data_i[31:30])
                    2'b00: begin
                        state_d = StI2cReq;
                        addr_d  = rom_data_i[23:8];
                        data_d  = rom_data_i[7:0];
                        retry_d = '0;
                    end
                    2'b01: begin
                        if (rom_data_i[23:8] == 16'd0) begin
                            advance = 1'b1;
                        end else begin
                            state_d = StDelay;
                            cnt_d   = delay_cycles - 32'd1;
                        end
                    end
                    default: begin
                        state_d = StLockWait;
                        cnt_d   = '0;
                    end
                endcase
            end
            StI2cReq: begin
                if (i2c_ready_i) state_d = StI2cWait;
            end
            StI2cWait: begin
                if (i2c_done_i) begin
                    if (!i2c_nack_i) begin
                        advance = 1'b1;
                    end else if (retry_q < MAX_RETRY) begin
                        retry_d = retry_q + 32'd1;
                        state_d = StI2cReq;
                    end else begin
                        state_d = StError;
                        code_d  = 2'd1;
                    end
                end
            end
            StDelay: begin
                if (cnt_q == 32'd0) advance = 1'b1;
                else                cnt_d   = cnt_q - 32'd1;
            end
            StLockWait: begin
                if (pll_lock_i) begin
                    state_d = StDone;
                end else if (cnt_q >= LockLimit) begin
                    state_d = StError;
                    code_d  = 2'd2;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Running off the end of the table acts as an implicit END.
        if (advance) begin
            if (idx_q == LastIdx) begin
                state_d = StLockWait;
                cnt_d   = '0;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = StFetch;
            end
        end
    end

    assign rom_addr_o     = idx_q;
    assign i2c_req_o      = (state_q == StI2cReq);
    assign i2c_addr_o     = addr_q;
    assign i2c_data_o     = data_q;
    assign done_o         = (state_q == StDone);
    assign mipi_reset_n_o = (state_q == StDone);
    assign error_o        = (state_q == StError);
    assign busy_o         = !(state_q inside {StIdle, StDone, StError});
    assign err_code_o     = code_q;

endmodule

// File: tb/tb_cam_init_sequencer.sv
// Bench for cam_init_sequencer: ROM and I2C master models, a table-walking reference model
// feeding a scoreboard of expected writes, and a negedge monitor checking accepted requests.
module tb_cam_init_sequencer;

    localparam int unsigned AW    = 5;
    localparam int unsigned DU    = 10;
    localparam int unsigned MR    = 3;
    localparam int unsigned LT    = 100;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset, start;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_data;
    logic          i2c_req, i2c_ready, i2c_done, i2c_nack;
    logic [15:0]   i2c_addr;
    logic [7:0]    i2c_data;
    logic          pll_lock, mipi_rst_n, busy, done, error;
    logic [1:0]    err_code;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] rom [DEPTH];
    bit          nack_plan [256];
    int          m_txn;
    int          rlo, rhi, dlo, dhi;

    logic [23:0] exp_q [$];
    int          acc_times [$];

    cam_init_sequencer #(
        .ADDR_W      (AW),
        .DELAY_UNIT  (DU),
        .MAX_RETRY   (MR),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .rom_addr_o    (rom_addr),
        .rom_data_i    (rom_data),
        .i2c_req_o     (i2c_req),
        .i2c_addr_o    (i2c_addr),
        .i2c_data_o    (i2c_data),
        .i2c_ready_i   (i2c_ready),
        .i2c_done_i    (i2c_done),
        .i2c_nack_i    (i2c_nack),
        .pll_lock_i    (pll_lock),
        .mipi_reset_n_o(mipi_rst_n),
        .busy_o        (busy),
        .done_o        (done),
        .error_o       (error),
        .err_code_o    (err_code)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rom_data <= rom[rom_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] wr(input logic [15:0] a, input logic [7:0] d);
        return {2'b00, 6'h0, a, d};
    endfunction

    function automatic logic [31:0] dly(input logic [15:0] t);
        return {2'b01, 6'h0, t, 8'h0};
    endfunction

    localparam logic [31:0] EndOp = {2'b10, 30'h0};

    // I2C master: random accept latency, then a done pulse whose NACK follows nack_plan.
    initial begin : master
        bit accepted, req_prev, pend;
        int rwait, wait_c;
        i2c_ready = 1'b0;
        i2c_done  = 1'b0;
        i2c_nack  = 1'b0;
        req_prev  = 1'b0;
        pend      = 1'b0;
        rwait     = 0;
        wait_c    = 0;
        forever begin
            @(posedge clk);
            #1;
            accepted  = i2c_ready && req_prev;
            i2c_ready = 1'b0;
            i2c_done  = 1'b0;
            i2c_nack  = 1'b0;
            if (reset) begin
                pend = 1'b0;
            end else if (accepted) begin
                pend   = 1'b1;
                wait_c = $urandom_range(dhi, dlo);
            end else if (pend) begin
                if (wait_c == 0) begin
                    i2c_done = 1'b1;
                    i2c_nack = nack_plan[m_txn];
                    m_txn++;
                    pend = 1'b0;
                end else begin
                    wait_c--;
                end
            end else if (i2c_req) begin
                if (!req_prev) rwait = $urandom_range(rhi, rlo);
                if (rwait == 0) i2c_ready = 1'b1;
                else            rwait--;
            end
            req_prev = i2c_req;
        end
    end

    // Monitor: request stability, accept contents against the scoreboard, req drop after accept.
    bit          in_req = 1'b0, stable = 1'b1, after_acc = 1'b0;
    logic [15:0] hold_addr;
    logic [7:0]  hold_data;
    always @(negedge clk) begin
        if (reset) begin
            in_req    = 1'b0;
            after_acc = 1'b0;
        end else begin
            if (after_acc) check("req_drop_after_accept", 32'(i2c_req), 32'd0);
            after_acc = 1'b0;
            if (i2c_req) begin
                if (!in_req) stable = 1'b1;
                else if (i2c_addr !== hold_addr || i2c_data !== hold_data) stable = 1'b0;
                in_req    = 1'b1;
                hold_addr = i2c_addr;
                hold_data = i2c_data;
                if (i2c_ready) begin
                    acc_times.push_back(cyc);
                    check("req_stable", 32'(stable), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_accept", {8'h0, i2c_addr, i2c_data}, 32'hFFFFFFFF);
                    end else begin
                        logic [23:0] e;
                        e = exp_q.pop_front();
                        check("write_addr_data", {8'h0, i2c_addr, i2c_data}, {8'h0, e});
                    end
                    in_req    = 1'b0;
                    after_acc = 1'b1;
                end
            end else begin
                in_req = 1'b0;
            end
        end
    end

    // Reference: walk the table by its op rules and predict writes and the final outcome.
    task automatic run_seq(input string tag, input bit lock, output int n);
        int  t, retries;
        bit  err;
        int  exp_code;
        logic [1:0] op;
        exp_q.delete();
        acc_times.delete();
        t   = 0;
        err = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            op = rom[i][31:30];
            if (op[1]) break;
            if (op == 2'b01) continue;
            retries = 0;
            forever begin
                exp_q.push_back(rom[i][23:0]);
                t++;
                if (!nack_plan[t-1]) break;
                if (retries < int'(MR)) begin
                    retries++;
                end else begin
                    err = 1'b1;
                    break;
                end
            end
            if (err) break;
        end
        exp_code = err ? 1 : (lock ? 0 : 2);
        pll_lock = lock;
        m_txn    = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'(exp_code == 0));
        check({tag, "_error"}, 32'(error), 32'(exp_code != 0));
        check({tag, "_err_code"}, 32'(err_code), 32'(exp_code));
        check({tag, "_mipi_reset_n"}, 32'(mipi_rst_n), 32'(exp_code == 0));
        check({tag, "_writes_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic clear_nacks();
        for (int i = 0; i < 256; i++) nack_plan[i] = 1'b0;
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n, g_d2, g_d0, g_none;
        reset    = 1'b1;
        start    = 1'b0;
        pll_lock = 1'b0;
        m_txn    = 0;
        rlo = 0; rhi = 0; dlo = 1; dhi = 1;
        clear_nacks();
        for (int i = 0; i < int'(DEPTH); i++) rom[i] = EndOp;
        repeat (3) @(negedge clk);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_outputs", {i2c_req, i2c_addr, i2c_data, mipi_rst_n, busy, done, error,
                              err_code}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // T1: two writes then END, lock high
        rom[0] = wr(16'h0100, 8'h00);
        rom[1] = wr(16'h3000, 8'h12);
        rom[2] = EndOp;
        run_seq("t1", 1'b1, n);

        // T2: accept held off 5 cycles
        rlo = 5; rhi = 5; dlo = 0; dhi = 3;
        run_seq("t2", 1'b1, n);
        check("t2_accepts", 32'(acc_times.size()), 32'd2);

        // T3: four NACKs on the first write
        rlo = 0; rhi = 2;
        for (int i = 0; i < 4; i++) nack_plan[i] = 1'b1;
        run_seq("t3", 1'b1, n);
        check("t3_requests", 32'(acc_times.size()), 32'd4);
        clear_nacks();

        // T4: delay timing relative to DELAY 0 and to no delay entry
        rlo = 0; rhi = 0; dlo = 1; dhi = 1;
        rom[0] = wr(16'h0010, 8'hA1);
        rom[1] = dly(16'd2);
        rom[2] = wr(16'h0011, 8'hA2);
        rom[3] = EndOp;
        run_seq("t4a", 1'b1, n);
        g_d2 = (acc_times.size() == 2) ? acc_times[1] - acc_times[0] : 0;
        rom[1] = dly(16'd0);
        run_seq("t4b", 1'b1, n);
        g_d0 = (acc_times.size() == 2) ? acc_times[1] - acc_times[0] : 0;
        rom[1] = wr(16'h0011, 8'hA2);
        rom[2] = EndOp;
        run_seq("t4c", 1'b1, n);
        g_none = (acc_times.size() == 2) ? acc_times[1] - acc_times[0] : 0;
        check("t4_delay_gap", 32'((g_d2 - g_d0 >= 18) && (g_d2 - g_d0 <= 22)), 32'd1);
        check("t4_delay0_no_stall", 32'((g_d0 - g_none >= 0) && (g_d0 - g_none <= 2)), 32'd1);

        // T5: lock timeout, then restart with lock
        rom[0] = EndOp;
        run_seq("t5a", 1'b0, n);
        check("t5_timeout_cycle", 32'((n >= 100) && (n <= 104)), 32'd1);
        run_seq("t5b", 1'b1, n);

        // T6a: full table of writes, no END
        for (int i = 0; i < int'(DEPTH); i++) rom[i] = wr(16'(16'h2000 + i), 8'(i * 7));
        rlo = 0; rhi = 1; dlo = 0; dhi = 1;
        run_seq("t6a", 1'b1, n);
        check("t6_accepts", 32'(acc_times.size()), 32'd32);

        // Randomized tables
        rlo = 0; rhi = 6; dlo = 0; dhi = 4;
        for (int r = 0; r < 12; r++) begin
            int k;
            for (int i = 0; i < int'(DEPTH); i++) begin
                k = $urandom_range(9, 0);
                if (k < 6)       rom[i] = wr(16'($urandom), 8'($urandom));
                else if (k < 8)  rom[i] = dly(16'($urandom_range(3, 0)));
                else if (k == 8) rom[i] = EndOp;
                else             rom[i] = {2'b11, 30'($urandom)};
                rom[i][29:24] = 6'($urandom);
            end
            for (int i = 0; i < 256; i++) nack_plan[i] = ($urandom_range(2, 0) == 0);
            run_seq("rand", 1'($urandom_range(3, 0) != 0), n);
        end
        clear_nacks();

        // T6b: reset while a write is outstanding
        for (int i = 0; i < int'(DEPTH); i++) rom[i] = wr(16'(16'h4000 + i), 8'(i));
        rlo = 0; rhi = 0; dlo = 20; dhi = 20;
        exp_q.delete();
        acc_times.delete();
        for (int i = 0; i < int'(DEPTH); i++) exp_q.push_back(rom[i][23:0]);
        pll_lock = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (acc_times.size() == 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("t6b_first_accept", 32'(acc_times.size()), 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6b_rst_rom_addr", 32'(rom_addr), 32'd0);
        check("t6b_rst_outputs", {i2c_req, i2c_addr, i2c_data, mipi_rst_n, busy, done, error,
                                  err_code}, 32'd0);
        reset = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
